// File: rtl/janus_alu_pkg.sv
// Shared function-code encodings for the Janus ALU.
// The function code is {class[2:0], op[5:0]}.
package janus_alu_pkg;

  localparam logic [2:0] CLS_ARITH = 3'b000;
  localparam logic [2:0] CLS_MUL   = 3'b001;
  localparam logic [2:0] CLS_LOGIC = 3'b010;
  localparam logic [2:0] CLS_NOP   = 3'b100;

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_ADC   = 6'd2;
  localparam logic [5:0] OP_SBC   = 6'd3;

  localparam logic [5:0] OP_MUL   = 6'd0;
  localparam logic [5:0] OP_MULHU = 6'd1;

  localparam logic [5:0] OP_AND   = 6'd0;
  localparam logic [5:0] OP_OR    = 6'd1;
  localparam logic [5:0] OP_XOR   = 6'd2;
  localparam logic [5:0] OP_LSL   = 6'd3;
  localparam logic [5:0] OP_LSR   = 6'd4;

endpackage

// File: rtl/janus_alu_shifter.sv
// Combinational logical shifter with carry-out of the last bit shifted out.
// A zero shift amount yields carry 0.
module janus_alu_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   amt,
  input  logic             right,
  output logic [WIDTH-1:0] res,
  output logic             carry
);

  // One guard bit on the exit side catches the last bit shifted out.
  logic [WIDTH:0] lsl_ext;
  logic [WIDTH:0] lsr_ext;

  always_comb begin
    lsl_ext = {1'b0, a} << amt;
    lsr_ext = {a, 1'b0} >> amt;
    if (right) begin
      res   = lsr_ext[WIDTH:1];
      carry = lsr_ext[0];
    end else begin
      res   = lsl_ext[WIDTH-1:0];
      carry = lsl_ext[WIDTH];
    end
  end

endmodule

// File: rtl/janus_alu.sv
// Registered 32-bit Janus ALU: arithmetic, multiply, logic and shift.
// Results and flags appear one cycle after the function code is sampled.
module janus_alu
  import janus_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inp_a,
  input  logic [WIDTH-1:0] inp_b,
  input  logic [8:0]       fnct_sel,
  output logic [WIDTH-1:0] out,
  output logic             cf,
  output logic             nf,
  output logic             zf,
  output logic             vf,
  output logic             alu_ack
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0]   out_reg, out_next;
  logic               cf_reg, cf_next;
  logic               vf_reg, vf_next;
  logic               nf_reg, zf_reg;
  logic               ack_reg;
  logic               valid;

  logic [2:0]         cls;
  logic [5:0]         op;
  logic [WIDTH-1:0]   b_eff;
  logic               cin;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   sh_res;
  logic               sh_carry;

  assign cls = fnct_sel[8:6];
  assign op  = fnct_sel[5:0];

  janus_alu_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .a     (inp_a),
    .amt   (inp_b[SHW-1:0]),
    .right (op == OP_LSR),
    .res   (sh_res),
    .carry (sh_carry)
  );

  // Subtraction is a + ~b + carry_in, so carry-out is NOT borrow.
  always_comb begin
    b_eff = inp_b;
    cin   = 1'b0;
    unique case (op)
      OP_SUB:  begin b_eff = ~inp_b; cin = 1'b1;   end
      OP_ADC:  begin cin = cf_reg;                 end
      OP_SBC:  begin b_eff = ~inp_b; cin = cf_reg; end
      default: ;
    endcase
    sum     = {1'b0, inp_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    product = {{WIDTH{1'b0}}, inp_a} * {{WIDTH{1'b0}}, inp_b};
  end

  always_comb begin
    out_next = out_reg;
    cf_next  = cf_reg;
    vf_next  = vf_reg;
    valid    = 1'b0;
    case (cls)
      CLS_ARITH: begin
        if (op <= OP_SBC) begin
          valid    = 1'b1;
          out_next = sum[WIDTH-1:0];
          cf_next  = sum[WIDTH];
          vf_next  = (inp_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                     (sum[WIDTH-1] != inp_a[WIDTH-1]);
        end
      end
      CLS_MUL: begin
        if (op == OP_MUL || op == OP_MULHU) begin
          valid    = 1'b1;
          out_next = (op == OP_MUL) ? product[WIDTH-1:0] : product[2*WIDTH-1:WIDTH];
          cf_next  = 1'b0;
          vf_next  = 1'b0;
        end
      end
      CLS_LOGIC: begin
        valid   = 1'b1;
        cf_next = 1'b0;
        vf_next = 1'b0;
        case (op)
          OP_AND:  out_next = inp_a & inp_b;
          OP_OR:   out_next = inp_a | inp_b;
          OP_XOR:  out_next = inp_a ^ inp_b;
          OP_LSL, OP_LSR: begin
            out_next = sh_res;
            cf_next  = sh_carry;
          end
          default: begin
            valid    = 1'b0;
            out_next = out_reg;
            cf_next  = cf_reg;
            vf_next  = vf_reg;
          end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg <= '0;
      cf_reg  <= 1'b0;
      nf_reg  <= 1'b0;
      zf_reg  <= 1'b0;
      vf_reg  <= 1'b0;
      ack_reg <= 1'b0;
    end else begin
      ack_reg <= valid;
      if (valid) begin
        out_reg <= out_next;
        cf_reg  <= cf_next;
        vf_reg  <= vf_next;
        nf_reg  <= out_next[WIDTH-1];
        zf_reg  <= (out_next == '0);
      end
    end
  end

  assign out     = out_reg;
  assign cf      = cf_reg;
  assign nf      = nf_reg;
  assign zf      = zf_reg;
  assign vf      = vf_reg;
  assign alu_ack = ack_reg;

endmodule

// File: tb/tb_janus_alu.sv
// Directed-vector bench for janus_alu; flags are compared packed as {cf,nf,zf,vf}.
module tb_janus_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inp_a, inp_b;
  logic [8:0]  fnct_sel;
  logic [31:0] out;
  logic        cf, nf, zf, vf, alu_ack;

  int checks   = 0;
  int failures = 0;

  janus_alu dut (
    .clk      (clk),
    .rst      (rst),
    .inp_a    (inp_a),
    .inp_b    (inp_b),
    .fnct_sel (fnct_sel),
    .out      (out),
    .cf       (cf),
    .nf       (nf),
    .zf       (zf),
    .vf       (vf),
    .alu_ack  (alu_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one vector, let one edge sample it, then compare outputs 1ns later.
  task automatic step(input string tag, input logic r, input logic [31:0] a,
                      input logic [31:0] b, input logic [8:0] f,
                      input logic [31:0] exp_out, input logic [3:0] exp_flags,
                      input logic exp_ack);
    rst      = r;
    inp_a    = a;
    inp_b    = b;
    fnct_sel = f;
    @(posedge clk);
    #1;
    $display("txn %-10s rst=%0b a=%h b=%h f=%h -> out=%h cnzv=%b ack=%b",
             tag, r, a, b, f, out, {cf, nf, zf, vf}, alu_ack);
    check({tag, ".out"}, out, exp_out);
    check({tag, ".flags"}, {28'd0, cf, nf, zf, vf}, {28'd0, exp_flags});
    check({tag, ".ack"}, {31'd0, alu_ack}, {31'd0, exp_ack});
  endtask

  initial begin
    rst = 1'b1; inp_a = '0; inp_b = '0; fnct_sel = 9'h100;
    @(negedge clk);
    //    tag          rst   a             b             f       out           cnzv     ack
    step("reset",     1'b1, 32'd0,        32'd0,        9'h100, 32'd0,        4'b0000, 1'b0);
    step("nop",       1'b0, 32'd8,        32'd4,        9'h100, 32'd0,        4'b0000, 1'b0);
    step("add",       1'b0, 32'd8,        32'd4,        9'h000, 32'd12,       4'b0000, 1'b1);
    step("sub",       1'b0, 32'd8,        32'd4,        9'h001, 32'd4,        4'b1000, 1'b1);
    step("mul",       1'b0, 32'd8,        32'd4,        9'h040, 32'd32,       4'b0000, 1'b1);
    step("mulhu",     1'b0, 32'd8,        32'd4,        9'h041, 32'd0,        4'b0010, 1'b1);
    step("mulhu_big", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 9'h041, 32'hFFFFFFFE, 4'b0100, 1'b1);
    step("and",       1'b0, 32'd8,        32'd4,        9'h080, 32'd0,        4'b0010, 1'b1);
    step("or",        1'b0, 32'd8,        32'd4,        9'h081, 32'd12,       4'b0000, 1'b1);
    step("xor",       1'b0, 32'd8,        32'd4,        9'h082, 32'd12,       4'b0000, 1'b1);
    step("lsl",       1'b0, 32'd8,        32'd4,        9'h083, 32'd128,      4'b0000, 1'b1);
    step("lsr",       1'b0, 32'd8,        32'd4,        9'h084, 32'd0,        4'b1010, 1'b1);
    step("lsl31",     1'b0, 32'd3,        32'd31,       9'h083, 32'h80000000, 4'b1100, 1'b1);
    step("lsr0",      1'b0, 32'h80000001, 32'd0,        9'h084, 32'h80000001, 4'b0100, 1'b1);
    step("add_ovf",   1'b0, 32'h7FFFFFFF, 32'd1,        9'h000, 32'h80000000, 4'b0101, 1'b1);
    step("add_wrap",  1'b0, 32'hFFFFFFFF, 32'd1,        9'h000, 32'd0,        4'b1010, 1'b1);
    step("adc_c1",    1'b0, 32'd0,        32'd0,        9'h002, 32'd1,        4'b0000, 1'b1);
    step("sub_neg",   1'b0, 32'd3,        32'd4,        9'h001, 32'hFFFFFFFF, 4'b0100, 1'b1);
    step("sbc_c0",    1'b0, 32'd10,       32'd3,        9'h003, 32'd6,        4'b1000, 1'b1);
    step("sbc_c1",    1'b0, 32'd10,       32'd3,        9'h003, 32'd7,        4'b1000, 1'b1);
    step("sub_vf",    1'b0, 32'h80000000, 32'd1,        9'h001, 32'h7FFFFFFF, 4'b1001, 1'b1);
    step("add_hold",  1'b0, 32'h7FFFFFFF, 32'd1,        9'h000, 32'h80000000, 4'b0101, 1'b1);
    step("inv_cls",   1'b0, 32'd1,        32'd1,        9'h0C0, 32'h80000000, 4'b0101, 1'b0);
    step("inv_op_ar", 1'b0, 32'd1,        32'd1,        9'h005, 32'h80000000, 4'b0101, 1'b0);
    step("inv_op_lg", 1'b0, 32'd1,        32'd1,        9'h085, 32'h80000000, 4'b0101, 1'b0);
    step("inv_op_mu", 1'b0, 32'd1,        32'd1,        9'h042, 32'h80000000, 4'b0101, 1'b0);
    step("inv_cls7",  1'b0, 32'd1,        32'd1,        9'h1C0, 32'h80000000, 4'b0101, 1'b0);
    step("rst_win",   1'b1, 32'd8,        32'd4,        9'h000, 32'd0,        4'b0000, 1'b0);
    step("post_rst",  1'b0, 32'd8,        32'd4,        9'h000, 32'd12,       4'b0000, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/janus_alu.md
Name: janus_alu

Overview:
- 32-bit registered integer ALU for the Janus datapath: arithmetic, multiply, logic and shift on two operands.
- Produces result plus C/N/Z/V flags and a one-cycle-latency acknowledge to the issuing controller.
- Operation is selected by a 9-bit function code: 3-bit class in [8:6], 6-bit op in [5:0].

Parameters:
- WIDTH, 32, operand/result width. Flag positions and shift-amount width (log2 WIDTH = 5) follow from it.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset. Named without the _b suffix because it is not active-low.
- inp_a  input  32  operand A.
- inp_b  input  32  operand B; shift amount is inp_b[4:0].
- fnct_sel  input  9  function code: class [8:6], op [5:0].
- out  output  32  registered result.
- cf  output  1  carry flag, registered.
- nf  output  1  negative flag, registered.
- zf  output  1  zero flag, registered.
- vf  output  1  signed overflow flag, registered.
- alu_ack  output  1  result/flags valid for the op sampled on the previous edge.

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on rising clk.
- Reset values: out = 0, cf/nf/zf/vf = 0, alu_ack = 0. Reset overrides any op sampled on the same edge.
- Each rising edge samples inp_a, inp_b and fnct_sel. Latency is 1 cycle. No internal state other than the output registers.
- Valid op: on the next edge, out and flags update and alu_ack = 1.
- NOP or invalid code: out and all flags hold; alu_ack = 0.
- alu_ack is a level. It stays high on consecutive cycles while valid ops are presented; a held fnct_sel re-executes every cycle.
- Class 000, arithmetic:
  - op 0 ADD: a+b.
  - op 1 SUB: a-b.
  - op 2 ADC: a+b+cf, using the registered cf.
  - op 3 SBC: a-b-!cf.
  - For these ops: cf = carry-out. For subtract ops cf = NOT borrow (a>=b unsigned gives cf = 1). vf = signed overflow.
- Class 001, multiply (unsigned 32x32):
  - op 0 MUL: low 32 bits.
  - op 1 MULHU: high 32 bits.
  - cf = vf = 0.
- Class 010, logic/shift:
  - op 0 AND, op 1 OR, op 2 XOR.
  - op 3 LSL: a << b[4:0].
  - op 4 LSR: logical a >> b[4:0].
  - vf = 0.
  - cf for shifts = last bit shifted out; cf = 0 for a shift amount of 0 and for AND/OR/XOR.
- Class 100: NOP/idle.
- Classes 011, 101, 110, 111 and unlisted op codes are invalid and behave as NOP.
- For every valid op: nf = out[31], zf = (out == 0).
- All arithmetic wraps modulo 2^32.

Decomposition:
- Package janus_alu_pkg: class localparams CLS_ARITH=3'b000, CLS_MUL=3'b001, CLS_LOGIC=3'b010, CLS_NOP=3'b100.
- Same package: op localparams OP_ADD..OP_SBC, OP_MUL, OP_MULHU, OP_AND, OP_OR, OP_XOR, OP_LSL, OP_LSR.
- One sub-module, janus_alu_shifter: combinational LSL/LSR with carry-out. All remaining logic stays in janus_alu.

Test Plan:
- Reset: pulse rst high for 1 cycle with fnct_sel=9'h100 → out=0, all flags 0, alu_ack=0. Hold NOP → outputs unchanged, alu_ack=0.
- a=8, b=4:
  - ADD (9'h000) → out=12, flags 0, alu_ack=1 next cycle.
  - SUB (9'h001) → out=4, cf=1, nf=zf=vf=0.
- a=8, b=4:
  - MUL (9'h040) → 32.
  - MULHU (9'h041) → 0, zf=1, cf=vf=0.
- a=8, b=4:
  - AND (9'h080) → 0, zf=1.
  - OR (9'h081) → 12.
  - XOR (9'h082) → 12.
  - LSL (9'h083) → 128, cf=0.
  - LSR (9'h084) → 0, zf=1, cf=1.
- Arithmetic boundaries:
  - 0x7FFFFFFF+1 → 0x80000000, vf=1, nf=1, cf=0.
  - 0xFFFFFFFF+1 → 0, cf=1, zf=1.
  - Then ADC 0+0 → 1.
  - 3-4 SUB → 0xFFFFFFFF, cf=0, nf=1.
- Invalid class 9'h0C0 after ADD → out and flags hold, alu_ack=0.
- Reset asserted alongside a valid op → reset wins.
